// File: rtl/hesap_pkg.sv
// Shared constants for the calculator's trig units: fixed-point constants,
// CORDIC arctangent table and the arcsine sequencer states.
package hesap_pkg;

  localparam logic [31:0] PI_2       = 32'h0001_9220;
  localparam logic [63:0] ONE_Q32_32 = 64'h0000_0001_0000_0000;
  localparam logic [33:0] K_Q3_30    = 34'h0_26DD_3B6A;

  typedef enum logic [2:0] {IDLE, CHECK, LAUNCH, RUN, CMP, DONE} state_t;

  // atan(2^-i) in Q3.30, truncated
  function automatic logic [33:0] atan_q330(input logic [4:0] i);
    logic [33:0] v;
    v = '0;
    case (i)
      5'd0:  v = 34'h0_3243_F6A8;
      5'd1:  v = 34'h0_1DAC_6705;
      5'd2:  v = 34'h0_0FAD_BAFC;
      5'd3:  v = 34'h0_07F5_6EA6;
      5'd4:  v = 34'h0_03FE_AB76;
      5'd5:  v = 34'h0_01FF_D55B;
      5'd6:  v = 34'h0_00FF_FAAA;
      5'd7:  v = 34'h0_007F_FF55;
      5'd8:  v = 34'h0_003F_FFEA;
      5'd9:  v = 34'h0_001F_FFFD;
      5'd10: v = 34'h0_000F_FFFF;
      5'd11: v = 34'h0_0007_FFFF;
      5'd12: v = 34'h0_0003_FFFF;
      5'd13: v = 34'h0_0001_FFFF;
      5'd14: v = 34'h0_0000_FFFF;
      5'd15: v = 34'h0_0000_7FFF;
      5'd16: v = 34'h0_0000_3FFF;
      5'd17: v = 34'h0_0000_1FFF;
      5'd18: v = 34'h0_0000_0FFF;
      5'd19: v = 34'h0_0000_07FF;
      5'd20: v = 34'h0_0000_03FF;
      5'd21: v = 34'h0_0000_01FF;
      5'd22: v = 34'h0_0000_00FF;
      5'd23: v = 34'h0_0000_007F;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_sin.sv
// Iterative rotation-mode CORDIC sine, Q3.30; result valid ITER cycles after start.
// No backpressure: start restarts the rotation, sin_out holds once busy drops.
module cordic_sin import hesap_pkg::*; #(
  parameter int ITER = 24,
  parameter int IW   = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [IW-1:0] angle,
  output logic          busy,
  output logic [IW-1:0] sin_out
);

  localparam int CW = $clog2(ITER + 1);

  logic signed [IW-1:0] r_x, r_y, r_z;
  logic [CW-1:0]        r_i;
  logic signed [IW-1:0] w_xs, w_ys, w_atan;
  logic                 w_ccw;

  assign w_xs    = r_x >>> r_i;
  assign w_ys    = r_y >>> r_i;
  assign w_atan  = IW'(atan_q330(5'(r_i)));
  assign w_ccw   = ~r_z[IW-1];
  assign sin_out = r_y;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_z  <= '0;
      r_i  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      r_x  <= IW'(K_Q3_30);
      r_y  <= '0;
      r_z  <= angle;
      r_i  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      // rotate toward z == 0; x starts at K so no gain fix-up is needed
      if (w_ccw) begin
        r_x <= r_x - w_ys;
        r_y <= r_y + w_xs;
        r_z <= r_z - w_atan;
      end else begin
        r_x <= r_x + w_ys;
        r_y <= r_y - w_xs;
        r_z <= r_z + w_atan;
      end
      r_i <= r_i + CW'(1);
      if (r_i == CW'(ITER - 1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/arcsinus.sv
// asin of a Q32.32 operand as Q16.16 radians by 17-step bisection over a CORDIC sine.
// Fixed latency (444 cycles, 2 for |x|>=1); one op at a time, basla ignored while hazir=0.
module arcsinus import hesap_pkg::*; #(
  parameter int ITER = 24,
  parameter int IW   = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        basla,
  input  logic [63:0] sayi1,
  output logic        hazir,
  output logic        gecerli,
  output logic [31:0] sonuc,
  output logic        tasma
);

  localparam int CW = $clog2(ITER + 1);

  state_t        r_state;
  logic [63:0]   r_x;
  logic          r_s;
  logic          r_err;
  logic [31:0]   r_tgt;
  logic [16:0]   r_a;
  logic [4:0]    r_k;
  logic [CW-1:0] r_cnt;
  logic          r_rej;

  logic [63:0]   w_mag;
  logic [16:0]   w_t;
  logic          w_t_ok;
  logic          w_start;
  logic          w_busy;
  logic [IW-1:0] w_angle, w_sin, w_tgt;

  assign w_mag   = r_x[63] ? -r_x : r_x;
  assign w_t     = r_a | (17'd1 << r_k);
  assign w_t_ok  = {15'd0, w_t} <= PI_2;
  assign w_start = (r_state == LAUNCH) && w_t_ok;
  assign w_angle = IW'({w_t, 14'd0});
  assign w_tgt   = IW'(r_tgt);

  cordic_sin #(.ITER(ITER), .IW(IW)) u_sin (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_start),
    .angle   (w_angle),
    .busy    (w_busy),
    .sin_out (w_sin)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      hazir   <= 1'b1;
      gecerli <= 1'b0;
      sonuc   <= '0;
      tasma   <= 1'b0;
      r_x     <= '0;
      r_s     <= 1'b0;
      r_err   <= 1'b0;
      r_tgt   <= '0;
      r_a     <= '0;
      r_k     <= '0;
      r_cnt   <= '0;
      r_rej   <= 1'b0;
    end else begin
      gecerli <= 1'b0;
      case (r_state)
        IDLE: if (basla) begin
          r_x     <= sayi1;
          hazir   <= 1'b0;
          r_state <= CHECK;
        end
        CHECK: begin
          // the most-negative operand negates to itself and lands in the error branch
          r_s   <= r_x[63];
          r_tgt <= w_mag[33:2];
          r_err <= 1'b0;
          if (w_mag > ONE_Q32_32) begin
            r_a     <= '0;
            r_err   <= 1'b1;
            r_state <= DONE;
          end else if (w_mag == ONE_Q32_32) begin
            r_a     <= PI_2[16:0];
            r_state <= DONE;
          end else begin
            r_a     <= '0;
            r_k     <= 5'd16;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_rej   <= ~w_t_ok;
          r_cnt   <= '0;
          r_state <= RUN;
        end
        RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) r_state <= CMP;
        end
        CMP: begin
          if (!r_rej && !w_busy && ($signed(w_sin) <= $signed(w_tgt))) r_a <= w_t;
          if (r_k == 5'd0) begin
            r_state <= DONE;
          end else begin
            r_k     <= r_k - 5'd1;
            r_state <= LAUNCH;
          end
        end
        DONE: begin
          sonuc   <= r_s ? -{15'd0, r_a} : {15'd0, r_a};
          tasma   <= r_err;
          gecerli <= 1'b1;
          hazir   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
